reg_dump_sequencer: RTL and testbench

Debug-side controller that sequences a full register-file dump. On a start request it walks every register address, drives the register file's debug read port, captures each word, and serialises it as bytes over a valid/ready byte stream toward the debug UART transmitter. It sits between the debug unit and the InstructionDecoder register file, and owns the read address only while `o_busy` is high.

---
 rtl/reg_dump_sequencer.sv | 155 +++++++++++++++
 tb/tb_reg_dump_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_sequencer.sv
// Register-file dump sequencer: walks every register address, captures each word and streams it
// LSB-first as bytes. Defining DUMP_CHECKSUM_EN appends one XOR checksum byte to each dump.

module reg_dump_sequencer #(
  parameter int REG_ADDRS_BITS = 5,
  parameter int PROC_BITS      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  output logic                      o_busy,
  output logic [REG_ADDRS_BITS-1:0] o_reg_addr,
  input  logic [PROC_BITS-1:0]      i_reg_data,
  output logic [7:0]                o_byte,
  output logic                      o_byte_valid,
  input  logic                      i_byte_ready,
  output logic                      o_done
);

  localparam int BPW   = PROC_BITS / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(BPW - 1);
  localparam logic [REG_ADDRS_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SEND,
`ifdef DUMP_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t                    state_q, state_n;
  logic [REG_ADDRS_BITS-1:0] addr_q, addr_n;
  logic [PROC_BITS-1:0]      shift_q, shift_n;
  logic [IDX_W-1:0]          idx_q, idx_n;
  logic                      valid_q, valid_n;
  logic                      busy_q, busy_n;
  logic                      done_q, done_n;
  logic                      handshake;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]                csum_q, csum_n;
`endif

  assign handshake    = valid_q & i_byte_ready;
  assign o_busy       = busy_q;
  assign o_reg_addr   = addr_q;
  assign o_byte       = shift_q[7:0];
  assign o_byte_valid = valid_q;
  assign o_done       = done_q;

  // The low byte of the shift register is always the byte on offer.
  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    shift_n = shift_q;
    idx_n   = idx_q;
`ifdef DUMP_CHECKSUM_EN
    csum_n  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          state_n = WAIT;
          addr_n  = '0;
`ifdef DUMP_CHECKSUM_EN
          csum_n  = '0;
`endif
        end
      end
      WAIT: begin
        shift_n = i_reg_data;
        idx_n   = '0;
        state_n = SEND;
      end
      SEND: begin
        if (handshake) begin
`ifdef DUMP_CHECKSUM_EN
          csum_n = csum_q ^ shift_q[7:0];
`endif
          if (idx_q == LAST_IDX) begin
            if (addr_q == LAST_ADDR) begin
`ifdef DUMP_CHECKSUM_EN
              shift_n[7:0] = csum_q ^ shift_q[7:0];
              state_n      = CHK;
`else
              state_n      = DONE;
`endif
            end else begin
              addr_n  = addr_q + REG_ADDRS_BITS'(1);
              state_n = WAIT;
            end
          end else begin
            shift_n = shift_q >> 8;
            idx_n   = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CHK: begin
        if (handshake) state_n = DONE;
      end
`endif
      DONE: begin
        state_n = IDLE;
        addr_n  = '0;
      end
      default: state_n = IDLE;
    endcase

    // Abort withdraws valid without a handshake and suppresses the done pulse.
    if (i_abort && state_q != IDLE) begin
      state_n = IDLE;
      addr_n  = '0;
    end

`ifdef DUMP_CHECKSUM_EN
    valid_n = (state_n == SEND) || (state_n == CHK);
`else
    valid_n = (state_n == SEND);
`endif
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      shift_q <= shift_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Directed self-checking bench for reg_dump_sequencer: full dump, backpressure, abort,
// ignored starts and asynchronous reset, with a negedge-read register file model.

module tb_reg_dump_sequencer;

`ifdef DUMP_CHECKSUM_EN
  localparam int STREAM_LEN = 129;
  localparam int DONE_FULL  = 161;
  localparam int DONE_BP    = 290;
`else
  localparam int STREAM_LEN = 128;
  localparam int DONE_FULL  = 160;
  localparam int DONE_BP    = 288;
`endif
  localparam int NBYTES = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        i_abort;
  logic        o_busy;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_done;

  logic [31:0] regs [32];
  logic [7:0]  cap_q [$];
  int          done_cnt = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  reg_dump_sequencer #(.REG_ADDRS_BITS(5), .PROC_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .o_busy(o_busy),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data), .o_byte(o_byte),
    .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Register file debug port settles on the falling edge.
  always @(negedge clk) i_reg_data <= regs[o_reg_addr];

  always @(posedge clk) begin
    if (o_byte_valid && i_byte_ready) cap_q.push_back(o_byte);
    if (o_done) done_cnt++;
  end

  function automatic logic [7:0] model_byte(input int j);
    logic [31:0] w;
    w = regs[j / 4];
    return w[8 * (j % 4) +: 8];
  endfunction

  function automatic int stream_errs();
    int e = 0;
    for (int j = 0; j < NBYTES; j++)
      if (j >= cap_q.size() || cap_q[j] !== model_byte(j)) e++;
    return e;
  endfunction

  task automatic do_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int start_k, output int k);
    k = start_k;
    while (!o_done && k < 2000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_reg_addr !== 5'd0) $display("[TB] FAIL reset_addr: got %0d want 0", o_reg_addr); else pass_cnt++;
    total_cnt++; if (o_byte !== 8'h00) $display("[TB] FAIL reset_byte: got %h want 00", o_byte); else pass_cnt++;
    total_cnt++; if (o_byte_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", o_byte_valid); else pass_cnt++;
    total_cnt++; if (o_done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", o_done); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    int k;
    logic [7:0] x;
    cap_q.delete();
    i_byte_ready = 1'b1;
    do_start();
    total_cnt++; if (o_busy !== 1'b1) $display("[TB] FAIL full_busy: got %b want 1", o_busy); else pass_cnt++;
    total_cnt++; if (o_byte_valid !== 1'b0) $display("[TB] FAIL full_wait_valid: got %b want 0", o_byte_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (o_byte_valid !== 1'b1) $display("[TB] FAIL full_first_valid: got %b want 1", o_byte_valid); else pass_cnt++;
    wait_done(1, k);
    total_cnt++; if (k !== DONE_FULL) $display("[TB] FAIL full_done_cycle: got %0d want %0d", k, DONE_FULL); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b1) $display("[TB] FAIL full_busy_in_done: got %b want 1", o_busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (o_done !== 1'b0 || o_busy !== 1'b0) $display("[TB] FAIL full_after_done: done=%b busy=%b want 0 0", o_done, o_busy); else pass_cnt++;
    total_cnt++; if (cap_q.size() !== STREAM_LEN) $display("[TB] FAIL full_len: got %0d want %0d", cap_q.size(), STREAM_LEN); else pass_cnt++;
    for (int j = 4; j < 8; j++) begin
      x = (j < cap_q.size()) ? cap_q[j] : 8'hxx;
      total_cnt++; if (x !== 8'h11) $display("[TB] FAIL full_byte%0d: got %h want 11", j, x); else pass_cnt++;
    end
    k = stream_errs();
    total_cnt++; if (k !== 0) $display("[TB] FAIL full_stream: %0d bad bytes, want 0", k); else pass_cnt++;
`ifdef DUMP_CHECKSUM_EN
    x = (cap_q.size() > NBYTES) ? cap_q[NBYTES] : 8'hxx;
    total_cnt++; if (x !== 8'h00) $display("[TB] FAIL full_checksum: got %h want 00", x); else pass_cnt++;
`endif
  endtask

  task automatic test_backpressure();
    int k = 0;
    int stalls = 0;
    int hold_err = 0;
    int e;
    logic ph = 1'b1;
    logic pv, pr;
    logic [7:0] pb, x;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
    regs[5] = 32'hA1B2C3D4;
    cap_q.delete();
    i_byte_ready = 1'b1;
    do_start();
    pv = o_byte_valid; pr = i_byte_ready; pb = o_byte;
    while (!o_done && k < 2000) begin
      @(negedge clk);
      k++;
      if (pv && !pr) begin
        stalls++;
        if (o_byte !== pb || o_byte_valid !== 1'b1) hold_err++;
      end
      if (o_byte_valid) begin
        ph = ~ph;
        i_byte_ready = ph;
      end
      pv = o_byte_valid; pr = i_byte_ready; pb = o_byte;
    end
    i_byte_ready = 1'b1;
    total_cnt++; if (k !== DONE_BP) $display("[TB] FAIL bp_done_cycle: got %0d want %0d", k, DONE_BP); else pass_cnt++;
    total_cnt++; if (stalls !== STREAM_LEN) $display("[TB] FAIL bp_stalls: got %0d want %0d", stalls, STREAM_LEN); else pass_cnt++;
    total_cnt++; if (hold_err !== 0) $display("[TB] FAIL bp_hold: %0d unstable cycles, want 0", hold_err); else pass_cnt++;
    for (int j = 0; j < 4; j++) begin
      x = (20 + j < cap_q.size()) ? cap_q[20 + j] : 8'hxx;
      total_cnt++; if (x !== exp_b[j]) $display("[TB] FAIL bp_byte%0d: got %h want %h", 20 + j, x, exp_b[j]); else pass_cnt++;
    end
    e = stream_errs();
    total_cnt++; if (e !== 0) $display("[TB] FAIL bp_stream: %0d bad bytes, want 0", e); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int k = 0;
    int dc;
    cap_q.delete();
    i_byte_ready = 1'b1;
    do_start();
    while (cap_q.size() < 38 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    total_cnt++; if (cap_q.size() !== 38) $display("[TB] FAIL abort_reach: got %0d bytes want 38", cap_q.size()); else pass_cnt++;
    total_cnt++; if (o_reg_addr !== 5'd9) $display("[TB] FAIL abort_addr9: got %0d want 9", o_reg_addr); else pass_cnt++;
    total_cnt++; if (o_byte !== model_byte(38)) $display("[TB] FAIL abort_byte2: got %h want %h", o_byte, model_byte(38)); else pass_cnt++;
    dc = done_cnt;
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    total_cnt++; if (o_byte_valid !== 1'b0) $display("[TB] FAIL abort_valid: got %b want 0", o_byte_valid); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_reg_addr !== 5'd0) $display("[TB] FAIL abort_addr: got %0d want 0", o_reg_addr); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (done_cnt !== dc) $display("[TB] FAIL abort_no_done: got %0d pulses want %0d", done_cnt, dc); else pass_cnt++;
    cap_q.delete();
    do_start();
    @(negedge clk);
    total_cnt++; if (o_reg_addr !== 5'd0 || o_byte_valid !== 1'b1) $display("[TB] FAIL abort_restart: addr=%0d valid=%b want 0 1", o_reg_addr, o_byte_valid); else pass_cnt++;
    wait_done(1, k);
    total_cnt++; if (k !== DONE_FULL) $display("[TB] FAIL abort_restart_done: got %0d want %0d", k, DONE_FULL); else pass_cnt++;
    @(negedge clk);
    k = stream_errs();
    total_cnt++; if (k !== 0) $display("[TB] FAIL abort_restart_stream: %0d bad bytes, want 0", k); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int k = 0;
    i_byte_ready = 1'b1;
    do_start();
    while (k < 50) begin
      @(negedge clk);
      k++;
    end
    total_cnt++; if (o_reg_addr !== 5'd10 || o_byte_valid !== 1'b0) $display("[TB] FAIL ign_pos: addr=%0d valid=%b want 10 0", o_reg_addr, o_byte_valid); else pass_cnt++;
    i_start = 1'b1;
    @(negedge clk);
    k++;
    i_start = 1'b0;
    total_cnt++; if (o_reg_addr !== 5'd10 || o_byte_valid !== 1'b1) $display("[TB] FAIL ign_busy_start: addr=%0d valid=%b want 10 1", o_reg_addr, o_byte_valid); else pass_cnt++;
    wait_done(k, k);
    total_cnt++; if (k !== DONE_FULL) $display("[TB] FAIL ign_done_cycle: got %0d want %0d", k, DONE_FULL); else pass_cnt++;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    total_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL ign_done_start: busy=%b want 0", o_busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL ign_not_queued: busy=%b want 0", o_busy); else pass_cnt++;
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    total_cnt++; if (o_busy !== 1'b0 || o_reg_addr !== 5'd0) $display("[TB] FAIL ign_start_abort: busy=%b addr=%0d want 0 0", o_busy, o_reg_addr); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL ign_start_abort_after: busy=%b want 0", o_busy); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int k = 0;
    i_byte_ready = 1'b1;
    do_start();
    while (!(o_reg_addr == 5'd17 && o_busy && !o_byte_valid) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    total_cnt++; if (k !== 85) $display("[TB] FAIL arst_reach: got %0d want 85", k); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (o_busy !== 1'b0 || o_byte_valid !== 1'b0 || o_done !== 1'b0) $display("[TB] FAIL arst_flags: busy=%b valid=%b done=%b want 0 0 0", o_busy, o_byte_valid, o_done); else pass_cnt++;
    total_cnt++; if (o_reg_addr !== 5'd0) $display("[TB] FAIL arst_addr: got %0d want 0", o_reg_addr); else pass_cnt++;
    total_cnt++; if (o_byte !== 8'h00) $display("[TB] FAIL arst_byte: got %h want 00", o_byte); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL arst_idle: busy=%b want 0", o_busy); else pass_cnt++;
    cap_q.delete();
    do_start();
    @(negedge clk);
    total_cnt++; if (o_reg_addr !== 5'd0 || o_byte_valid !== 1'b1) $display("[TB] FAIL arst_restart: addr=%0d valid=%b want 0 1", o_reg_addr, o_byte_valid); else pass_cnt++;
    wait_done(1, k);
    @(negedge clk);
    k = stream_errs();
    total_cnt++; if (k !== 0) $display("[TB] FAIL arst_stream: %0d bad bytes, want 0", k); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_byte_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h11111111 * 32'(i % 16);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_async_reset();
    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
